// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM encoding and the divide-by-zero quotient.
package mult_div_unit_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } md_state_e;

  localparam logic [MD_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  function automatic logic is_signed_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Sign handling shared by multiply and divide: operand magnitudes going in,
// two's-complement correction of the unsigned results coming out.
module md_sign_fix
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_op,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               neg_a,
  output logic               neg_b,
  input  logic [2*WIDTH-1:0] prod_in,
  input  logic [WIDTH-1:0]   quo_in,
  input  logic [WIDTH-1:0]   rem_in,
  input  logic               neg_res,
  input  logic               neg_rem,
  output logic [2*WIDTH-1:0] prod_out,
  output logic [WIDTH-1:0]   quo_out,
  output logic [WIDTH-1:0]   rem_out
);

  // The most negative value maps onto itself and is then read as unsigned.
  assign neg_a = signed_op & a[WIDTH-1];
  assign neg_b = signed_op & b[WIDTH-1];
  assign mag_a = neg_a ? ({WIDTH{1'b0}} - a) : a;
  assign mag_b = neg_b ? ({WIDTH{1'b0}} - b) : b;

  assign prod_out = neg_res ? ({(2*WIDTH){1'b0}} - prod_in) : prod_in;
  assign quo_out  = neg_res ? ({WIDTH{1'b0}} - quo_in) : quo_in;
  assign rem_out  = neg_rem ? ({WIDTH{1'b0}} - rem_in) : rem_in;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Fixed 33-cycle latency: one shift-add or restoring step per CALC cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH   = MD_WIDTH,
  parameter int COUNT_W = 6
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [1:0]       mdOp,
  input  logic [WIDTH-1:0] readData,
  input  logic [WIDTH-1:0] readData2,
  input  logic             writeHi,
  input  logic             writeLo,
  input  logic [WIDTH-1:0] mtData,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int DW = 2 * WIDTH;
  localparam logic [COUNT_W-1:0] LAST_ITER = COUNT_W'(WIDTH - 1);

  md_state_e          state_r, state_nxt_s;
  md_op_e             op_r, op_in_s;
  logic [COUNT_W-1:0] count_r, count_nxt_s;
  logic [DW-1:0]      work_r, work_nxt_s;
  logic [WIDTH-1:0]   operand_r;
  logic [WIDTH-1:0]   dividend_r;
  logic               neg_res_r, neg_rem_r, div_zero_r;
  logic [WIDTH-1:0]   hi_r, lo_r, hi_nxt_s, lo_nxt_s;
  logic               busy_r, done_r, busy_nxt_s, done_nxt_s;
  logic               launch_s, signed_in_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic               neg_a_s, neg_b_s;
  logic [DW-1:0]      prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s;
  logic [WIDTH-1:0]   div_sub_s;
  logic [DW-1:0]      mul_step_s, div_step_s;

  assign op_in_s     = md_op_e'(mdOp);
  assign signed_in_s = is_signed_op(op_in_s);

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .a         (readData),
    .b         (readData2),
    .signed_op (signed_in_s),
    .mag_a     (mag_a_s),
    .mag_b     (mag_b_s),
    .neg_a     (neg_a_s),
    .neg_b     (neg_b_s),
    .prod_in   (work_r),
    .quo_in    (work_r[WIDTH-1:0]),
    .rem_in    (work_r[DW-1:WIDTH]),
    .neg_res   (neg_res_r),
    .neg_rem   (neg_rem_r),
    .prod_out  (prod_fix_s),
    .quo_out   (quo_fix_s),
    .rem_out   (rem_fix_s)
  );

  // Multiply: work = {partial, multiplier}; add on LSB, shift right with carry.
  assign mul_sum_s  = {1'b0, work_r[DW-1:WIDTH]} +
                      (work_r[0] ? {1'b0, operand_r} : {(WIDTH+1){1'b0}});
  assign mul_step_s = {mul_sum_s, work_r[WIDTH-1:1]};

  // Divide: work = {remainder, dividend/quotient}; shift left, trial subtract.
  assign div_shift_s = {work_r[DW-1:WIDTH], work_r[WIDTH-1]};
  assign div_sub_s   = div_shift_s[WIDTH-1:0] - operand_r;
  assign div_step_s  = (div_shift_s >= {1'b0, operand_r}) ?
                       {div_sub_s, work_r[WIDTH-2:0], 1'b1} :
                       {work_r[DW-2:0], 1'b0};

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start ? CALC : IDLE;
      CALC:    state_nxt_s = (count_r == LAST_ITER) ? FINISH : CALC;
      FINISH:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and output next values per state.
  always_comb begin
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    work_nxt_s  = work_r;
    count_nxt_s = count_r;
    launch_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          launch_s    = 1'b1;
          busy_nxt_s  = 1'b1;
          count_nxt_s = {COUNT_W{1'b0}};
          work_nxt_s  = {{WIDTH{1'b0}}, (is_div_op(op_in_s) ? mag_a_s : mag_b_s)};
        end else begin
          hi_nxt_s = writeHi ? mtData : hi_r;
          lo_nxt_s = writeLo ? mtData : lo_r;
        end
      end
      CALC: begin
        work_nxt_s  = is_div_op(op_r) ? div_step_s : mul_step_s;
        count_nxt_s = count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
      FINISH: begin
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b1;
        count_nxt_s = {COUNT_W{1'b0}};
        if (is_div_op(op_r)) begin
          if (div_zero_r) begin
            lo_nxt_s = WIDTH'(DIV0_QUOTIENT);
            hi_nxt_s = dividend_r;
          end else begin
            lo_nxt_s = quo_fix_s;
            hi_nxt_s = rem_fix_s;
          end
        end else begin
          hi_nxt_s = prod_fix_s[DW-1:WIDTH];
          lo_nxt_s = prod_fix_s[WIDTH-1:0];
        end
      end
      default: begin
        busy_nxt_s  = 1'b0;
        count_nxt_s = {COUNT_W{1'b0}};
      end
    endcase
  end

  // Architectural and iteration registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      work_r  <= {DW{1'b0}};
      count_r <= {COUNT_W{1'b0}};
    end else begin
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      work_r  <= work_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Operands and sign decisions captured once at launch.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      op_r       <= MD_MULT;
      operand_r  <= {WIDTH{1'b0}};
      dividend_r <= {WIDTH{1'b0}};
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
    end else if (launch_s) begin
      op_r       <= op_in_s;
      operand_r  <= is_div_op(op_in_s) ? mag_b_s : mag_a_s;
      dividend_r <= readData;
      neg_res_r  <= neg_a_s ^ neg_b_s;
      neg_rem_r  <= neg_a_s;
      div_zero_r <= (readData2 == {WIDTH{1'b0}});
    end else begin
      op_r       <= op_r;
      operand_r  <= operand_r;
      dividend_r <= dividend_r;
      neg_res_r  <= neg_res_r;
      neg_rem_r  <= neg_rem_r;
      div_zero_r <= div_zero_r;
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes reference results,
// an independent monitor pops and compares them on every done pulse.
module tb_mult_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          e0;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mdOp = 2'b00;
  logic [31:0] readData = 32'd0;
  logic [31:0] readData2 = 32'd0;
  logic        writeHi = 1'b0;
  logic        writeLo = 1'b0;
  logic [31:0] mtData = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int busy_cnt = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;
  exp_t sb_q[$];

  mult_div_unit dut (
    .clk(clk), .resetN(resetN), .start(start), .mdOp(mdOp),
    .readData(readData), .readData2(readData2),
    .writeHi(writeHi), .writeLo(writeLo), .mtData(mtData),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = longint'(ua / ub);
        r = longint'(ua % ub);
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_bit("idle_timeout", busy, 1'b0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic wlo);
    logic [63:0] r;
    logic [31:0] ph, pl;
    exp_t e;
    wait_idle();
    @(posedge clk);
    #1;
    mdOp = op; readData = a; readData2 = b; start = 1'b1;
    writeLo = wlo; mtData = $urandom;
    r = model(op, a, b);
    ph = cur_hi;
    pl = cur_lo;
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.e0 = cyc + 1;
    sb_q.push_back(e);
    cur_hi = r[63:32];
    cur_lo = r[31:0];
    @(posedge clk);
    #1;
    start = 1'b0; writeLo = 1'b0;
    mdOp = 2'($urandom); readData = $urandom; readData2 = $urandom;
    check_bit("busy_after_start", busy, 1'b1);
    check("hold_hi", hi, ph);
    check("hold_lo", lo, pl);
  endtask

  // Monitor: compares every done pulse against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (resetN !== 1'b1) begin
      busy_cnt = 0;
    end else begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_bit("spurious_done", done, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("result_hi", hi, e.hi);
          check("result_lo", lo, e.lo);
          check("latency", cyc - e.e0, 32'd33);
          check("busy_cycles", busy_cnt, 32'd33);
          check_bit("busy_at_done", busy, 1'b0);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] ph, v;
    int n;
    #2 resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    resetN = 1'b1;

    issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    issue(2'b11, 32'd100, 32'd0, 1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);

    // MTHI alone, then MTHI and MTLO together.
    wait_idle();
    @(posedge clk); #1;
    writeHi = 1'b1; mtData = 32'h0000_1234;
    @(posedge clk); #1;
    writeHi = 1'b0;
    cur_hi = 32'h0000_1234;
    check("mthi_hi", hi, cur_hi);
    check("mthi_lo_keep", lo, cur_lo);
    v = $urandom;
    writeHi = 1'b1; writeLo = 1'b1; mtData = v;
    @(posedge clk); #1;
    writeHi = 1'b0; writeLo = 1'b0;
    cur_hi = v; cur_lo = v;
    check("mt_both_hi", hi, v);
    check("mt_both_lo", lo, v);

    // start together with writeLo: write dropped, op runs.
    issue(2'b01, 32'd1000, 32'd3000, 1'b1);

    // start and writeHi while busy are ignored.
    ph = cur_hi;
    issue(2'b00, 32'h0000_1234, 32'hFFFF_FF00, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; mdOp = 2'b01; readData = 32'd5; readData2 = 32'd9;
    writeHi = 1'b1; mtData = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0; writeHi = 1'b0;
    check("busy_write_ignored", hi, ph);

    // Reset in the middle of a DIVU.
    issue(2'b11, $urandom, 32'($urandom_range(1, 1000)), 1'b0);
    repeat (14) @(posedge clk);
    #1 resetN = 1'b0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_done", done, 1'b0);
    sb_q.delete();
    cur_hi = 32'd0; cur_lo = 32'd0;
    @(posedge clk); #1 resetN = 1'b1;
    issue(2'b01, 32'd6, 32'd7, 1'b0);

    for (int i = 0; i < 30; i++) begin
      issue(2'($urandom), pick(), pick(), 1'($urandom));
    end

    n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
